jpl_foc_park: RTL and testbench

- Park transform stage, directly downstream of jpl_foc_clarke. Consumes o_ialpha/o_ibeta on o_clarke_done (wired to i_start_park) plus rotor-angle sin/cos. Produces rotating-frame currents for the d/q PI loops:
  - id = ialpha*cos + ibeta*sin
  - iq = -ialpha*sin + ibeta*cos
- Uses one shared signed multiplier, time-multiplexed by an FSM.

---
 rtl/jpl_foc_pkg.sv | 39 +++
 rtl/jpl_foc_mac.sv | 43 ++++
 rtl/jpl_foc_park.sv | 130 +++++++++++++
 tb/tb_jpl_foc_park.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jpl_foc_pkg.sv
// Shared FOC definitions: Park FSM states, MAC opcodes and the
// round-half-up / saturate helper used by the Park and inverse Park stages.
package jpl_foc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_D0,
        S_D1,
        S_Q0,
        S_Q1
    } park_state_t;

    typedef enum logic [1:0] {
        MAC_HOLD,
        MAC_LOAD,
        MAC_ADD,
        MAC_SUB
    } mac_op_t;

    // Rounding bias is 2^(b - RND_BIAS_SHIFT), i.e. half an output LSB after the >>> (b-1).
    localparam int RND_BIAS_SHIFT = 2;

    function automatic logic signed [31:0] f_sat_rnd(input logic signed [63:0] acc, input int b);
        logic signed [63:0] rounded;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rounded = (acc + (64'sd1 <<< (b - RND_BIAS_SHIFT))) >>> (b - 1);
        hi      = (64'sd1 <<< (b - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (b - 1));
        if (rounded > hi) begin
            f_sat_rnd = hi[31:0];
        end else if (rounded < lo) begin
            f_sat_rnd = lo[31:0];
        end else begin
            f_sat_rnd = rounded[31:0];
        end
    endfunction

endpackage

// File: rtl/jpl_foc_mac.sv
// Registered signed multiply-accumulate with load/add/sub/hold control.
// o_next is the value the accumulator takes on the next edge.
module jpl_foc_mac
    import jpl_foc_pkg::*;
#(
    parameter int B = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_op,
    input  logic signed [B-1:0]   i_x,
    input  logic signed [B-1:0]   i_y,
    output logic signed [2*B+1:0] o_next
);

    localparam int AW = 2 * B + 2;

    logic signed [2*B-1:0] prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  acc;

    assign prod     = i_x * i_y;
    assign prod_ext = AW'(prod);

    always_comb begin
        o_next = acc;
        case (mac_op_t'(i_op))
            MAC_LOAD: o_next = prod_ext;
            MAC_ADD:  o_next = acc + prod_ext;
            MAC_SUB:  o_next = acc - prod_ext;
            default:  o_next = acc;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
        end else begin
            acc <= o_next;
        end
    end

endmodule

// File: rtl/jpl_foc_park.sv
// Park transform: id = a*cos + b*sin, iq = b*cos - a*sin, computed over
// four cycles on one shared multiplier sequenced by a small FSM.
module jpl_foc_park
    import jpl_foc_pkg::*;
#(
    parameter int B = 12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start_park,
    input  logic signed [B-1:0] i_ialpha,
    input  logic signed [B-1:0] i_ibeta,
    input  logic signed [B-1:0] i_sin,
    input  logic signed [B-1:0] i_cos,
    output logic                o_busy,
    output logic                o_park_done,
    output logic signed [B-1:0] o_id,
    output logic signed [B-1:0] o_iq
);

    localparam int AW = 2 * B + 2;

    park_state_t state;
    park_state_t state_next;

    logic signed [B-1:0]  r_a;
    logic signed [B-1:0]  r_b;
    logic signed [B-1:0]  r_s;
    logic signed [B-1:0]  r_c;
    logic signed [B-1:0]  r_id;
    logic signed [B-1:0]  mac_x;
    logic signed [B-1:0]  mac_y;
    mac_op_t              mac_op;
    logic signed [AW-1:0] mac_next;

    jpl_foc_mac #(.B(B)) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_op    (mac_op),
        .i_x     (mac_x),
        .i_y     (mac_y),
        .o_next  (mac_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each state pairs one product with the accumulate action it feeds.
    always_comb begin
        state_next = state;
        mac_op     = MAC_HOLD;
        mac_x      = '0;
        mac_y      = '0;
        case (state)
            S_IDLE: begin
                if (i_start_park) begin
                    state_next = S_D0;
                end
            end
            S_D0: begin
                mac_op     = MAC_LOAD;
                mac_x      = r_a;
                mac_y      = r_c;
                state_next = S_D1;
            end
            S_D1: begin
                mac_op     = MAC_ADD;
                mac_x      = r_b;
                mac_y      = r_s;
                state_next = S_Q0;
            end
            S_Q0: begin
                mac_op     = MAC_LOAD;
                mac_x      = r_b;
                mac_y      = r_c;
                state_next = S_Q1;
            end
            S_Q1: begin
                mac_op     = MAC_SUB;
                mac_x      = r_a;
                mac_y      = r_s;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_c         <= '0;
            r_id        <= '0;
            o_id        <= '0;
            o_iq        <= '0;
            o_busy      <= 1'b0;
            o_park_done <= 1'b0;
        end else begin
            o_park_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start_park) begin
                        r_a    <= i_ialpha;
                        r_b    <= i_ibeta;
                        r_s    <= i_sin;
                        r_c    <= i_cos;
                        o_busy <= 1'b1;
                    end
                end
                S_D1: begin
                    r_id <= B'(f_sat_rnd(64'(mac_next), B));
                end
                S_Q1: begin
                    o_iq        <= B'(f_sat_rnd(64'(mac_next), B));
                    o_id        <= r_id;
                    o_park_done <= 1'b1;
                    o_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jpl_foc_park.sv
// Self-checking bench for jpl_foc_park at B=4: directed vector table,
// back-to-back and reset-abort sequences, and randomized transforms.
module tb_jpl_foc_park;

    localparam int TB_B = 4;

    typedef struct {
        int a;
        int b;
        int s;
        int c;
        int expId;
        int expIq;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic signed [TB_B-1:0] ialpha = '0;
    logic signed [TB_B-1:0] ibeta = '0;
    logic signed [TB_B-1:0] sinv = '0;
    logic signed [TB_B-1:0] cosv = '0;
    logic                   busy;
    logic                   done;
    logic signed [TB_B-1:0] id;
    logic signed [TB_B-1:0] iq;

    int checks = 0;
    int failures = 0;

    jpl_foc_park #(.B(TB_B)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start_park (start),
        .i_ialpha     (ialpha),
        .i_ibeta      (ibeta),
        .i_sin        (sinv),
        .i_cos        (cosv),
        .o_busy       (busy),
        .o_park_done  (done),
        .o_id         (id),
        .o_iq         (iq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: real-valued Park, scaled back by 2^(B-1), rounded half up, clamped.
    function automatic int refRound(input int x);
        int scale;
        int v;
        int q;
        scale = 1 << (TB_B - 1);
        v = x + scale / 2;
        q = (v >= 0) ? v / scale : -((-v + scale - 1) / scale);
        if (q > scale - 1) q = scale - 1;
        if (q < -scale) q = -scale;
        return q;
    endfunction

    function automatic int refId(input int a, input int b, input int s, input int c);
        return refRound(a * c + b * s);
    endfunction

    function automatic int refIq(input int a, input int b, input int s, input int c);
        return refRound(b * c - a * s);
    endfunction

    task automatic scrambleInputs();
        ialpha = TB_B'($urandom);
        ibeta  = TB_B'($urandom);
        sinv   = TB_B'($urandom);
        cosv   = TB_B'($urandom);
    endtask

    task automatic driveInputs(input int a, input int b, input int s, input int c);
        ialpha = TB_B'(a);
        ibeta  = TB_B'(b);
        sinv   = TB_B'(s);
        cosv   = TB_B'(c);
    endtask

    // Starts one transform and waits for done; inputs churn after capture.
    task automatic applyStimulus(input int a, input int b, input int s, input int c,
                                 input bit holdStart, output logic signed [31:0] gotId,
                                 output logic signed [31:0] gotIq, output int lat);
        @(negedge clk);
        driveInputs(a, b, s, c);
        start = 1'b1;
        @(negedge clk);
        lat = 0;
        start = holdStart;
        checkOutput("busy_after_start", 32'(busy), 1);
        scrambleInputs();
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            scrambleInputs();
        end
        start = 1'b0;
        gotId = 32'(id);
        gotIq = 32'(iq);
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic runVector(input string tag, input int a, input int b, input int s, input int c,
                             input int expId, input int expIq, input bit holdStart);
        logic signed [31:0] gotId;
        logic signed [31:0] gotIq;
        int lat;
        int extra;
        applyStimulus(a, b, s, c, holdStart, gotId, gotIq, lat);
        checkOutput({tag, "_latency"}, lat, 4);
        checkOutput({tag, "_id"}, gotId, expId);
        checkOutput({tag, "_iq"}, gotIq, expIq);
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 0);
        countDones(5, extra);
        checkOutput({tag, "_extra_done"}, extra, 0);
        checkOutput({tag, "_id_hold"}, 32'(id), expId);
    endtask

    vec_t tbl[7];

    initial begin
        logic signed [31:0] gotId;
        logic signed [31:0] gotIq;
        int lat;
        int cnt;
        int n;
        int ra, rb, rs, rc;

        tbl[0] = '{4, -4, 0, 7, 4, -3};
        tbl[1] = '{3, 2, -8, 0, -2, 3};
        tbl[2] = '{-8, -8, -8, -8, 7, 0};
        tbl[3] = '{-8, -8, 7, 7, -8, 0};
        tbl[4] = '{1, 0, 0, 4, 1, 0};
        tbl[5] = '{-1, 0, 0, 4, 0, 0};
        tbl[6] = '{-8, 7, 7, 7, -1, 7};

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_id", 32'(id), 0);
        checkOutput("reset_iq", 32'(iq), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            runVector($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c,
                      tbl[i].expId, tbl[i].expIq, 1'b0);
        end
        runVector("held_start", 4, -4, 0, 7, 4, -3, 1'b1);

        // Back-to-back: a start in the done cycle is accepted immediately.
        applyStimulus(3, 2, -8, 0, 1'b0, gotId, gotIq, lat);
        checkOutput("b2b_first_id", gotId, -2);
        checkOutput("b2b_first_iq", gotIq, 3);
        driveInputs(4, -4, 0, 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        while (done !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("b2b_spacing", cnt, 5);
        checkOutput("b2b_second_id", 32'(id), 4);
        checkOutput("b2b_second_iq", 32'(iq), -3);

        // Reset asserted just before E2 aborts the transform without a done.
        @(negedge clk);
        driveInputs(3, 2, -8, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_id", 32'(id), 0);
        checkOutput("abort_iq", 32'(iq), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        countDones(2, n);
        rst_n = 1'b1;
        countDones(6, cnt);
        checkOutput("abort_no_done", n + cnt, 0);
        runVector("after_abort", -8, 7, 7, 7, -1, 7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $signed(TB_B'($urandom));
            rb = $signed(TB_B'($urandom));
            rs = $signed(TB_B'($urandom));
            rc = $signed(TB_B'($urandom));
            applyStimulus(ra, rb, rs, rc, 1'($urandom_range(0, 1)), gotId, gotIq, lat);
            checkOutput($sformatf("rand%0d_latency", i), lat, 4);
            checkOutput($sformatf("rand%0d_id", i), gotId, refId(ra, rb, rs, rc));
            checkOutput($sformatf("rand%0d_iq", i), gotIq, refIq(ra, rb, rs, rc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
